// File: rtl/hub75_test_pattern_gen.sv
// Synthetic pattern source standing in for the HUB75 frame-buffer LSRAM read port.
// Optional macro TP_DIM_EN adds a dim_shift input that right-shifts the stage-1 colours.
module hub75_test_pattern_gen #(
    parameter int COLOR_BITS = 6,
    parameter int COL_BITS   = 9,
    parameter int ROW_BITS   = 5,
    parameter int PLANE_BASE = 2,
    parameter int RD_LATENCY = 2,
    parameter int SCROLL_DIV = 3
) (
    input  logic                         clk,
    input  logic                         resetn,
`ifdef TP_DIM_EN
    input  logic [1:0]                   dim_shift,
`endif
    input  logic                         rd_en,
    input  logic [COL_BITS+ROW_BITS-1:0] rd_addr,
    input  logic [2:0]                   rd_bit_plane,
    input  logic                         frame_start,
    input  logic [2:0]                   pattern_sel,
    input  logic                         pattern_req,
    output logic                         pattern_ack,
    output logic [2:0]                   active_pattern,
    output logic                         r0,
    output logic                         g0,
    output logic                         b0,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic                         rd_valid
);

    localparam int CB    = COLOR_BITS;
    localparam int PIX_W = 3 * CB;
    localparam int DLY_N = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
    localparam int LAST  = DLY_N - 1;

    typedef struct packed {
        logic             valid;
        logic [2:0]       plane;
        logic [PIX_W-1:0] top;
        logic [PIX_W-1:0] bot;
    } stage_t;

    function automatic logic [PIX_W-1:0] checker_color(input logic [1:0] k);
        logic [PIX_W-1:0] c;
        case (k)
            2'd1:    c = {{CB{1'b1}}, {(2*CB){1'b0}}};
            2'd2:    c = {{CB{1'b0}}, {CB{1'b1}}, {CB{1'b0}}};
            2'd3:    c = {{(2*CB){1'b0}}, {CB{1'b1}}};
            default: c = {PIX_W{1'b0}};
        endcase
        return c;
    endfunction

    function automatic logic [PIX_W-1:0] pix_color(input logic [2:0]          pat,
                                                   input logic [COL_BITS-1:0] col,
                                                   input logic [ROW_BITS:0]   row_full,
                                                   input logic [COL_BITS-1:0] scroll);
        logic [COL_BITS-1:0] scol;
        logic [1:0]          k_plain;
        logic [1:0]          k_scroll;
        logic [2:0]          idx;
        logic [CB-1:0]       ones;
        logic [CB-1:0]       zero;
        logic [PIX_W-1:0]    c;
        ones     = {CB{1'b1}};
        zero     = {CB{1'b0}};
        scol     = col + scroll;
        k_plain  = col[4:3] + row_full[ROW_BITS-1:ROW_BITS-2];
        k_scroll = scol[4:3] + row_full[ROW_BITS-1:ROW_BITS-2];
        idx      = col[COL_BITS-1:COL_BITS-3];
        case (pat)
            3'd1:    c = checker_color(k_plain);
            3'd2:    c = {idx[2] ? ones : zero, idx[1] ? ones : zero, idx[0] ? ones : zero};
            3'd3:    c = {col[COL_BITS-1:COL_BITS-CB], zero, zero};
            3'd4:    c = {ones, ones, ones};
            3'd5:    c = checker_color(k_scroll);
            3'd6:    c = {zero, CB'(row_full), zero};
            default: c = {PIX_W{1'b0}};
        endcase
        return c;
    endfunction

    function automatic logic [PIX_W-1:0] dim_color(input logic [PIX_W-1:0] c, input logic [1:0] sh);
        return {c[PIX_W-1:2*CB] >> sh, c[2*CB-1:CB] >> sh, c[CB-1:0] >> sh};
    endfunction

    function automatic logic sel_bit(input logic [CB-1:0] v, input logic [3:0] p);
        return |(v & (CB'(1) << p));
    endfunction

    logic [SCROLL_DIV-1:0] frame_cnt_r;
    logic [COL_BITS-1:0]   scroll_r;
    logic [2:0]            pending_sel_r;
    logic                  pending_vld_r;
    stage_t                st0_s;
    stage_t                src_s;
    stage_t                dly_r [DLY_N];
    logic [1:0]            shift_s;
    logic [3:0]            plane_off_s;
    logic                  plane_ok_s;
    logic [5:0]            bits_s;

`ifdef TP_DIM_EN
    assign shift_s = dim_shift;
`else
    assign shift_s = 2'd0;
`endif

    // Stage 1: decode address and evaluate the active pattern for both halves
    always_comb begin
        st0_s       = '0;
        st0_s.valid = rd_en;
        st0_s.plane = rd_bit_plane;
        st0_s.top   = dim_color(pix_color(active_pattern, rd_addr[COL_BITS-1:0],
                                          {1'b0, rd_addr[COL_BITS+ROW_BITS-1:COL_BITS]}, scroll_r), shift_s);
        st0_s.bot   = dim_color(pix_color(active_pattern, rd_addr[COL_BITS-1:0],
                                          {1'b1, rd_addr[COL_BITS+ROW_BITS-1:COL_BITS]}, scroll_r), shift_s);
    end

    // Final-stage plane select; codes outside the colour range yield black
    always_comb begin
        src_s       = (RD_LATENCY == 1) ? st0_s : dly_r[LAST];
        plane_off_s = {1'b0, src_s.plane} - 4'(PLANE_BASE);
        plane_ok_s  = ({1'b0, src_s.plane} >= 4'(PLANE_BASE)) && (plane_off_s < 4'(CB));
        if (plane_ok_s) begin
            bits_s = {sel_bit(src_s.top[PIX_W-1:2*CB], plane_off_s),
                      sel_bit(src_s.top[2*CB-1:CB],    plane_off_s),
                      sel_bit(src_s.top[CB-1:0],       plane_off_s),
                      sel_bit(src_s.bot[PIX_W-1:2*CB], plane_off_s),
                      sel_bit(src_s.bot[2*CB-1:CB],    plane_off_s),
                      sel_bit(src_s.bot[CB-1:0],       plane_off_s)};
        end else begin
            bits_s = 6'b000000;
        end
    end

    // Pure delay stages between colour evaluation and plane select
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DLY_N; i++) dly_r[i] <= '0;
        end else begin
            dly_r[0] <= st0_s;
            for (int i = 1; i < DLY_N; i++) dly_r[i] <= dly_r[i-1];
        end
    end

    // Registered pixel outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid                   <= 1'b0;
            {r0, g0, b0, r1, g1, b1}   <= 6'b000000;
        end else begin
            rd_valid                   <= src_s.valid;
            {r0, g0, b0, r1, g1, b1}   <= src_s.valid ? bits_s : 6'b000000;
        end
    end

    // Frame-synchronous pattern handshake and scroll animation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_sel_r  <= 3'd0;
            pending_vld_r  <= 1'b0;
            active_pattern <= 3'd0;
            pattern_ack    <= 1'b0;
            frame_cnt_r    <= '0;
            scroll_r       <= '0;
        end else begin
            pattern_ack <= frame_start && pending_vld_r;
            if (frame_start) begin
                frame_cnt_r <= frame_cnt_r + 1'b1;
                if (pending_vld_r) begin
                    active_pattern <= pending_sel_r;
                    pending_vld_r  <= 1'b0;
                    scroll_r       <= '0;
                end else if (frame_cnt_r == {SCROLL_DIV{1'b1}}) begin
                    scroll_r <= scroll_r + 1'b1;
                end else begin
                    scroll_r <= scroll_r;
                end
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            // A request in the same cycle as frame_start waits for the next boundary
            if (pattern_req) begin
                pending_sel_r <= pattern_sel;
                pending_vld_r <= 1'b1;
            end else begin
                pending_sel_r <= pending_sel_r;
            end
        end
    end

endmodule

// File: tb/tb_hub75_test_pattern_gen.sv
// Directed bench for hub75_test_pattern_gen: a RD_LATENCY=2 and a RD_LATENCY=4 instance share stimulus.
module tb_hub75_test_pattern_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rd_en;
    logic [13:0] rd_addr;
    logic [2:0]  rd_bit_plane;
    logic        frame_start;
    logic [2:0]  pattern_sel;
    logic        pattern_req;

    logic        ack2, ack4, v2, v4;
    logic [2:0]  act2, act4;
    logic        r0_2, g0_2, b0_2, r1_2, g1_2, b1_2;
    logic        r0_4, g0_4, b0_4, r1_4, g1_4, b1_4;
    logic [5:0]  rgb2, rgb4;

    int n_cmp = 0;
    int n_err = 0;

    assign rgb2 = {r0_2, g0_2, b0_2, r1_2, g1_2, b1_2};
    assign rgb4 = {r0_4, g0_4, b0_4, r1_4, g1_4, b1_4};

    always #5 clk = ~clk;

    hub75_test_pattern_gen #(.RD_LATENCY(2)) u_dut2 (
        .clk(clk), .resetn(resetn),
`ifdef TP_DIM_EN
        .dim_shift(2'b00),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_bit_plane(rd_bit_plane),
        .frame_start(frame_start), .pattern_sel(pattern_sel), .pattern_req(pattern_req),
        .pattern_ack(ack2), .active_pattern(act2),
        .r0(r0_2), .g0(g0_2), .b0(b0_2), .r1(r1_2), .g1(g1_2), .b1(b1_2), .rd_valid(v2)
    );

    hub75_test_pattern_gen #(.RD_LATENCY(4)) u_dut4 (
        .clk(clk), .resetn(resetn),
`ifdef TP_DIM_EN
        .dim_shift(2'b00),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_bit_plane(rd_bit_plane),
        .frame_start(frame_start), .pattern_sel(pattern_sel), .pattern_req(pattern_req),
        .pattern_ack(ack4), .active_pattern(act4),
        .r0(r0_4), .g0(g0_4), .b0(b0_4), .r1(r1_4), .g1(g1_4), .b1(b1_4), .rd_valid(v4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated read; exp is {r0,g0,b0,r1,g1,b1}
    task automatic do_read(input string tag, input logic [4:0] row, input logic [8:0] col,
                           input logic [2:0] plane, input logic [5:0] exp);
        rd_addr      = {row, col};
        rd_bit_plane = plane;
        rd_en        = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            rd_en = 1'b0;
            if (c == 1) chk({tag, " v2_early"}, 32'(v2), 32'd1 - 32'd1);
            if (c == 2) begin
                chk({tag, " v2"}, 32'(v2), 32'd1);
                chk({tag, " rgb2"}, 32'(rgb2), 32'(exp));
            end
            if (c == 3) chk({tag, " v4_early"}, 32'(v4), 32'd0);
            if (c == 4) begin
                chk({tag, " v4"}, 32'(v4), 32'd1);
                chk({tag, " rgb4"}, 32'(rgb4), 32'(exp));
            end
        end
    endtask

    task automatic set_pattern(input logic [2:0] sel);
        pattern_sel = sel;
        pattern_req = 1'b1;
        step();
        pattern_req = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("ack_pulse", 32'(ack2), 32'd1);
        chk("active", 32'(act2), 32'(sel));
        step();
        chk("ack_drop", 32'(ack2), 32'd0);
    endtask

    initial begin
        resetn       = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = 14'd0;
        rd_bit_plane = 3'd0;
        frame_start  = 1'b0;
        pattern_sel  = 3'd0;
        pattern_req  = 1'b0;
        step(); step(); step();
        chk("rst_valid", 32'(v2), 32'd0);
        chk("rst_ack", 32'(ack2), 32'd0);
        chk("rst_active", 32'(act2), 32'd0);
        chk("rst_rgb", 32'(rgb2), 32'd0);
        resetn = 1'b1;
        step();

        do_read("p0_black", 5'd0, 9'd0, 3'd2, 6'b000000);

        set_pattern(3'd1);
        do_read("p1_col8", 5'd0, 9'd8, 3'd3, 6'b100100);
        do_read("p1_row8", 5'd8, 9'd0, 3'd2, 6'b100100);
        do_read("p1_green", 5'd0, 9'd16, 3'd2, 6'b010010);
        do_read("p1_wrap", 5'd8, 9'd24, 3'd2, 6'b000000);

        set_pattern(3'd2);
        do_read("p2_pl7", 5'd0, 9'h1A0, 3'd7, 6'b110110);
        do_read("p2_pl1", 5'd0, 9'h1A0, 3'd1, 6'b000000);
        do_read("p2_pl2", 5'd0, 9'h1A0, 3'd2, 6'b110110);

        set_pattern(3'd3);
        do_read("p3_pl4", 5'd0, 9'h1A0, 3'd4, 6'b100100);
        do_read("p3_pl3", 5'd0, 9'h1A0, 3'd3, 6'b000000);

        set_pattern(3'd6);
        do_read("p6_pl2", 5'd5, 9'd0, 3'd2, 6'b010010);
        do_read("p6_pl7", 5'd5, 9'd0, 3'd7, 6'b000010);

        // Request coinciding with frame_start is deferred one frame
        pattern_sel = 3'd4;
        pattern_req = 1'b1;
        frame_start = 1'b1;
        step();
        pattern_req = 1'b0;
        frame_start = 1'b0;
        chk("same_cyc_ack", 32'(ack2), 32'd0);
        chk("same_cyc_active", 32'(act2), 32'd6);
        step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("deferred_ack", 32'(ack2), 32'd1);
        chk("deferred_active", 32'(act2), 32'd4);
        step();
        do_read("p4_white", 5'd3, 9'd100, 3'd5, 6'b111111);

        set_pattern(3'd5);
        do_read("p5_c7_s0", 5'd0, 9'd7, 3'd2, 6'b000000);
        do_read("p5_c8_s0", 5'd0, 9'd8, 3'd2, 6'b100100);
        for (int f = 0; f < 8; f++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
        do_read("p5_c7_s1", 5'd0, 9'd7, 3'd2, 6'b100100);
        do_read("p5_c15_s1", 5'd0, 9'd15, 3'd2, 6'b010010);

        // Back-to-back reads with an asynchronous reset in the middle
        set_pattern(3'd4);
        step(); step();
        rd_addr      = 14'd0;
        rd_bit_plane = 3'd2;
        rd_en        = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 10) begin
                chk("b2b_v2", 32'(v2), (i >= 1) ? 32'd1 : 32'd0);
                chk("b2b_v4", 32'(v4), (i >= 3) ? 32'd1 : 32'd0);
                if (i >= 1) chk("b2b_rgb2", 32'(rgb2), 32'h3F);
            end else if (i == 10) begin
                resetn = 1'b0;
                #1;
                chk("mid_rst_v2", 32'(v2), 32'd0);
                chk("mid_rst_v4", 32'(v4), 32'd0);
                chk("mid_rst_rgb2", 32'(rgb2), 32'd0);
                chk("mid_rst_rgb4", 32'(rgb4), 32'd0);
                #2;
                resetn = 1'b1;
            end else begin
                chk("post_rst_v2", 32'(v2), (i - 10 >= 2) ? 32'd1 : 32'd0);
                chk("post_rst_v4", 32'(v4), (i - 10 >= 4) ? 32'd1 : 32'd0);
                chk("post_rst_rgb2", 32'(rgb2), 32'd0);
            end
        end
        rd_en = 1'b0;
        chk("post_rst_active", 32'(act2), 32'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
